branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 120 ++++++++++++
 tb/tb_branch_predictor.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters,
// combinational mispredict detection and saturating performance counters.
module branch_predictor #(
  parameter int IDX_BITS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_br,
  input  logic [31:0] ex_pc,
  input  logic        ex_br_en,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 32 - IDX_BITS - 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       ctr;
  } entry_t;

  entry_t btb_q [ENTRIES];
  logic [31:0] br_count_q;
  logic [31:0] mispred_count_q;

  // Fetch-side lookup reads registered state only, so a same-cycle update
  // to the same index is not visible until the following cycle.
  logic [IDX_BITS-1:0] if_idx;
  entry_t              if_e;
  logic                if_hit;

  assign if_idx      = if_pc[IDX_BITS+1:2];
  assign if_e        = btb_q[if_idx];
  assign if_hit      = if_e.valid && (if_e.tag == if_pc[31:IDX_BITS+2]);
  assign pred_taken  = if_hit && if_e.ctr[1];
  assign pred_target = pred_taken ? if_e.target : if_pc + 32'd4;

  // Resolve-side view of the entry owning ex_pc.
  logic [IDX_BITS-1:0] ex_idx;
  entry_t              ex_e;
  logic                ex_hit;
  logic                actual_taken;
  logic [31:0]         actual_next;

  assign ex_idx       = ex_pc[IDX_BITS+1:2];
  assign ex_e         = btb_q[ex_idx];
  assign ex_hit       = ex_e.valid && (ex_e.tag == ex_pc[31:IDX_BITS+2]);
  assign actual_taken = ex_is_br ? ex_br_en : 1'b1;
  assign actual_next  = actual_taken ? ex_target : ex_pc + 32'd4;

  assign redirect    = !rst && ex_valid &&
                       ((ex_pred_taken != actual_taken) ||
                        (actual_taken && (ex_pred_target != ex_target)));
  assign redirect_pc = ex_valid ? actual_next : 32'd0;

  // Next contents of the resolving entry; a not-taken miss leaves it alone.
  entry_t ex_upd;
  logic   btb_we;

  assign btb_we = ex_valid && (ex_hit || actual_taken);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ex_upd = ex_e;
    if (ex_hit) begin
      if (ex_is_br) begin
        if (ex_br_en) begin
          if (ex_e.ctr != 2'd3) ex_upd.ctr = ex_e.ctr + 2'd1;
        end else begin
          if (ex_e.ctr != 2'd0) ex_upd.ctr = ex_e.ctr - 2'd1;
        end
      end else begin
        ex_upd.ctr = 2'd3;
      end
      if (actual_taken) ex_upd.target = ex_target;
    end else begin
      ex_upd.valid  = 1'b1;
      ex_upd.tag    = ex_pc[31:IDX_BITS+2];
      ex_upd.target = ex_target;
      ex_upd.ctr    = ex_is_br ? 2'd2 : 2'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the table is flop-based and fully reset, so it cannot map onto a RAM macro.
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: 32'd0, ctr: 2'd1};
      end
      br_count_q      <= 32'd0;
      mispred_count_q <= 32'd0;
    end else if (ex_valid) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (br_count_q != 32'hFFFF_FFFF) br_count_q <= br_count_q + 32'd1;
      if (redirect && (mispred_count_q != 32'hFFFF_FFFF))
        mispred_count_q <= mispred_count_q + 32'd1;
      if (btb_we) btb_q[ex_idx] <= ex_upd;
    end
  end

  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

  // The byte-offset bits of both PCs never participate in indexing or tags.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios followed by
// randomized traffic compared against an array-based behavioural model.
module tb_branch_predictor;

  localparam int IDX_BITS = 5;
  localparam int NENT     = 1 << IDX_BITS;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic        ex_is_br;
  logic [31:0] ex_pc;
  logic        ex_br_en;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  branch_predictor #(.IDX_BITS(IDX_BITS)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .ex_valid       (ex_valid),
    .ex_is_br       (ex_is_br),
    .ex_pc          (ex_pc),
    .ex_br_en       (ex_br_en),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .br_count       (br_count),
    .mispred_count  (mispred_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Behavioural model: one slot per index holding the full upper PC as tag.
  bit          m_valid [NENT];
  int unsigned m_tag   [NENT];
  int unsigned m_tgt   [NENT];
  int          m_ctr   [NENT];
  longint      m_br;
  longint      m_mis;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 4) % NENT);
  endfunction

  function automatic int unsigned upper(input logic [31:0] pc);
    return pc / (4 * NENT);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[slot(pc)] && (m_tag[slot(pc)] == upper(pc));
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_pred_tgt(input logic [31:0] pc);
    return m_pred(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_actual;
    return ex_is_br ? ex_br_en : 1'b1;
  endfunction

  function automatic bit m_redirect;
    bit act = m_actual();
    return !rst && ex_valid &&
           ((ex_pred_taken != act) || (act && ex_pred_target != ex_target));
  endfunction

  task automatic m_reset;
    for (int i = 0; i < NENT; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_br  = 0;
    m_mis = 0;
  endtask

  task automatic m_step;
    int s;
    bit act;
    bit hit;
    bit mis;
    s   = slot(ex_pc);
    act = m_actual();
    hit = m_hit(ex_pc);
    mis = m_redirect();
    if (rst) begin
      m_reset();
    end else if (ex_valid) begin
      if (m_br < 64'hFFFF_FFFF) m_br++;
      if (mis && m_mis < 64'hFFFF_FFFF) m_mis++;
      if (hit) begin
        if (ex_is_br) m_ctr[s] = ex_br_en ? ((m_ctr[s] == 3) ? 3 : m_ctr[s] + 1)
                                          : ((m_ctr[s] == 0) ? 0 : m_ctr[s] - 1);
        else          m_ctr[s] = 3;
        if (act) m_tgt[s] = ex_target;
      end else if (act) begin
        m_valid[s] = 1;
        m_tag[s]   = upper(ex_pc);
        m_tgt[s]   = ex_target;
        m_ctr[s]   = ex_is_br ? 2 : 3;
      end
    end
  endtask

  // Inputs are driven at the falling edge; tick checks outputs 1 time unit
  // later, then advances the model across the rising edge.
  task automatic tick;
    #1;
    check("pred_taken",  {31'd0, pred_taken}, {31'd0, m_pred(if_pc)});
    check("pred_target", pred_target, m_pred_tgt(if_pc));
    check("redirect",    {31'd0, redirect}, {31'd0, m_redirect()});
    check("redirect_pc", redirect_pc, ex_valid ? (m_actual() ? ex_target : ex_pc + 32'd4) : 32'd0);
    check("br_count",    br_count, m_br[31:0]);
    check("mispred_cnt", mispred_count, m_mis[31:0]);
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic idle;
    ex_valid = 0; ex_is_br = 0; ex_pc = 0; ex_br_en = 0; ex_target = 0;
    ex_pred_taken = 0; ex_pred_target = 0;
  endtask

  task automatic resolve(input bit is_br, input logic [31:0] pc, input bit en,
                         input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt);
    ex_valid = 1; ex_is_br = is_br; ex_pc = pc; ex_br_en = en; ex_target = tgt;
    ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  function automatic logic [31:0] pick_pc;
    logic [31:0] r;
    case ($urandom_range(0, 5))
      0: r = 32'h40;
      1: r = 32'h100;
      2: r = 32'h180;
      3: r = 32'h1040;
      4: r = 32'h44;
      default: r = $urandom & 32'hFFFF_FFFC;
    endcase
    return r;
  endfunction

  initial begin
    rst = 1; if_pc = 0; idle();
    @(negedge clk); @(negedge clk);
    m_reset();

    // Reset state visible at an arbitrary fetch PC.
    rst = 0; if_pc = 32'h60;
    tick();
    check("rst_pred_60", pred_target, 32'h64);

    // Taken branch mispredicted as not-taken allocates with ctr=2.
    resolve(1, 32'h40, 1, 32'h80, 0, 32'h44); if_pc = 32'h40;
    tick();
    idle();
    tick();
    check("alloc_tgt", pred_target, 32'h80);
    check("alloc_mis", mispred_count, 32'd1);

    // Four not-taken resolutions walk the counter down and saturate at 0.
    for (int k = 0; k < 4; k++) begin
      resolve(1, 32'h40, 0, 32'h80, m_pred(32'h40), m_pred_tgt(32'h40));
      tick();
    end
    idle();
    tick();
    check("nt_pred", {31'd0, pred_taken}, 32'd0);

    // jal: allocate, then a correct prediction leaves fetch alone.
    if_pc = 32'h100;
    resolve(0, 32'h100, 0, 32'h200, 0, 32'h104);
    tick();
    resolve(0, 32'h100, 0, 32'h200, 1, 32'h200);
    tick();
    check("jal_ok_redir", {31'd0, redirect}, 32'd0);
    check("jal_pred", pred_target, 32'h200);
    // Conflicting jal at the same index evicts 0x100.
    resolve(0, 32'h180, 0, 32'h300, 0, 32'h184);
    tick();
    idle();
    tick();
    check("evict_miss", pred_target, 32'h104);

    // Update presented under reset is discarded.
    rst = 1; if_pc = 32'h500;
    resolve(1, 32'h500, 1, 32'h900, 0, 32'h504);
    tick();
    rst = 0; idle();
    tick();
    check("rst_prio_tbl", pred_target, 32'h504);
    check("rst_prio_cnt", br_count, 32'd0);

    // br_count saturation via a forced preload.
    force dut.br_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.br_count_q;
    m_br = 64'hFFFF_FFFF;
    resolve(1, 32'h40, 1, 32'h80, 0, 32'h44);
    tick();
    idle();
    tick();
    check("br_sat", br_count, 32'hFFFF_FFFF);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pc;
      rst   = ($urandom_range(0, 49) == 0);
      if_pc = pick_pc();
      pc    = pick_pc();
      ex_valid  = ($urandom_range(0, 3) != 0);
      ex_is_br  = ($urandom_range(0, 3) != 0);
      ex_pc     = pc;
      ex_br_en  = $urandom_range(0, 1);
      ex_target = ($urandom_range(0, 1) != 0) ? 32'h800 : ($urandom & 32'hFFFF_FFFC);
      if ($urandom_range(0, 9) < 7) begin
        ex_pred_taken  = m_pred(pc);
        ex_pred_target = m_pred_tgt(pc);
      end else begin
        ex_pred_taken  = $urandom_range(0, 1);
        ex_pred_target = $urandom & 32'hFFFF_FFFC;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
